ddr_arbiter: RTL and testbench

//  Shares the single-port word memory (ddr_model) between two PicoRV32-style requesters: p0 (instruction fetch) and p1 (data/LSU).
//  - Round-robin arbitration; one transaction in flight at a time.
//  - Requester side: byte-addressed, byte-strobed.
//  - Memory side: word-addressed rd/wr pulses.
//  - Partial writes are done as read-modify-write.

---
 rtl/ddr_arb_pkg.sv | 24 ++
 rtl/ddr_arbiter_rr.sv | 21 ++
 rtl/ddr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ddr_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and helpers for the two-port DDR word-memory arbiter.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } state_t;

    localparam logic [3:0] STRB_FULL = 4'hF;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/ddr_arbiter_rr.sv
// Two-way round-robin grant; the previous winner loses a tie.
module rr_arbiter2
    import ddr_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (en) begin
            unique case (req)
                2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
                default: gnt = req;
            endcase
        end
    end

endmodule

// File: rtl/ddr_arbiter.sv
// Round-robin bridge from two byte-strobed requesters onto a single
// word memory; partial writes are performed as read-modify-write.
module ddr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  p0_valid,
    input  logic [31:0]           p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [3:0]            p0_wstrb,
    output logic                  p0_ready,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,
    input  logic                  p1_valid,
    input  logic [31:0]           p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic [3:0]            p1_wstrb,
    output logic                  p1_ready,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_valid
);

    state_t state_q, state_d;
    logic last_q, last_d;
    logic sel_q, sel_d;
    logic perr_q, perr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0] wstrb_q, wstrb_d;

    logic rd_d, wr_d;
    logic [AW-1:0] addr_d;
    logic [31:0] mwd_d, rd0_d, rd1_d;
    logic [1:0] rdy_d, err_d, gnt;
    logic [31:0] req_addr, req_wd;
    logic [3:0] req_ws;
    logic in_range;
    logic unused_lsb;

    assign unused_lsb = ^{p0_addr[1:0], p1_addr[1:0]};

    rr_arbiter2 u_rr (
        .req        ({p1_valid, p0_valid}),
        .last_grant (last_q),
        .en         (state_q == IDLE),
        .gnt        (gnt)
    );

    assign req_addr = gnt[1] ? p1_addr  : p0_addr;
    assign req_wd   = gnt[1] ? p1_wdata : p0_wdata;
    assign req_ws   = gnt[1] ? p1_wstrb : p0_wstrb;
    assign in_range = {2'b00, req_addr[31:2]} < 32'(DEPTH);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        perr_d  = perr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = mem_addr;
        mwd_d   = mem_wr_data;
        rdy_d   = '0;
        err_d   = '0;
        rd0_d   = '0;
        rd1_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    last_d  = gnt[1];
                    sel_d   = gnt[1];
                    wdata_d = req_wd;
                    wstrb_d = req_ws;
                    unique case (1'b1)
                        !in_range: begin
                            perr_d  = 1'b1;
                            state_d = RESP;
                        end
                        in_range && req_ws == STRB_FULL: begin
                            wr_d           = 1'b1;
                            addr_d         = req_addr[AW+1:2];
                            mwd_d          = req_wd;
                            rdy_d[gnt[1]]  = 1'b1;
                            state_d        = RESP;
                        end
                        default: begin
                            rd_d    = 1'b1;
                            addr_d  = req_addr[AW+1:2];
                            state_d = RD_WAIT;
                        end
                    endcase
                end
            end
            RD_WAIT: begin
                if (mem_rd_valid) begin
                    rdy_d[sel_q] = 1'b1;
                    state_d      = RESP;
                    if (wstrb_q == 4'h0) begin
                        if (sel_q) rd1_d = mem_rd_data;
                        else       rd0_d = mem_rd_data;
                    end else begin
                        wr_d  = 1'b1;
                        mwd_d = merge_bytes(mem_rd_data, wdata_q, wstrb_q);
                    end
                end
            end
            RESP: begin
                // Error responses spend one extra RESP cycle raising ready.
                if (perr_q) begin
                    perr_d       = 1'b0;
                    rdy_d[sel_q] = 1'b1;
                    err_d[sel_q] = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            perr_q      <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            p0_ready    <= 1'b0;
            p1_ready    <= 1'b0;
            p0_err      <= 1'b0;
            p1_err      <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            perr_q      <= perr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            mem_rd_req  <= rd_d;
            mem_wr_req  <= wr_d;
            mem_addr    <= addr_d;
            mem_wr_data <= mwd_d;
            p0_ready    <= rdy_d[0];
            p1_ready    <= rdy_d[1];
            p0_err      <= err_d[0];
            p1_err      <= err_d[1];
            p0_rdata    <= rd0_d;
            p1_rdata    <= rd1_d;
        end
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter with a one-cycle-latency word memory.
module tb_ddr_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  pv = '0;
    logic [31:0] pa [2];
    logic [31:0] pw [2];
    logic [3:0]  ps [2];
    logic [1:0]  pr, pe;
    logic [31:0] prd [2];
    logic        mem_rd_req, mem_wr_req;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data = '0;
    logic        mem_rd_valid = 1'b0;
    logic [31:0] mem [1024];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ddr_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .p0_valid     (pv[0]),
        .p0_addr      (pa[0]),
        .p0_wdata     (pw[0]),
        .p0_wstrb     (ps[0]),
        .p0_ready     (pr[0]),
        .p0_rdata     (prd[0]),
        .p0_err       (pe[0]),
        .p1_valid     (pv[1]),
        .p1_addr      (pa[1]),
        .p1_wdata     (pw[1]),
        .p1_wstrb     (ps[1]),
        .p1_ready     (pr[1]),
        .p1_rdata     (prd[1]),
        .p1_err       (pe[1]),
        .mem_rd_req   (mem_rd_req),
        .mem_wr_req   (mem_wr_req),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid)
    );

    always @(posedge clk) begin
        mem_rd_valid <= mem_rd_req;
        if (mem_rd_req) mem_rd_data <= mem[mem_addr];
        if (mem_wr_req) mem[mem_addr] <= mem_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic xact(input string tag, input int p, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] exp_rd, input logic [31:0] exp_wd,
                        input logic exp_err);
        int lat;
        lat = exp_err ? 1 : (ws == 4'hF ? 0 : 2);
        pa[p] = a;
        pw[p] = wd;
        ps[p] = ws;
        pv[p] = 1'b1;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            chk($sformatf("%s/rd_req@%0d", tag, c), 32'(mem_rd_req),
                32'(!exp_err && c == 0 && ws != 4'hF));
            chk($sformatf("%s/wr_req@%0d", tag, c), 32'(mem_wr_req),
                32'(!exp_err && ws != 4'h0 && c == lat));
            chk($sformatf("%s/ready@%0d", tag, c), 32'(pr[p]),
                32'(c == lat));
            chk($sformatf("%s/other_ready@%0d", tag, c), 32'(pr[1-p]), 0);
            if (c == 0 && !exp_err)
                chk($sformatf("%s/mem_addr", tag), 32'(mem_addr),
                    {22'd0, a[11:2]});
        end
        chk({tag, "/rdata"}, prd[p], exp_rd);
        chk({tag, "/err"}, 32'(pe[p]), 32'(exp_err));
        if (ws != 4'h0 && !exp_err)
            chk({tag, "/wr_data"}, mem_wr_data, exp_wd);
        pv[p] = 1'b0;
        @(negedge clk);
        chk({tag, "/ready_drop"}, 32'(pr[p]), 0);
    endtask

    initial begin
        int seq[$];
        for (int i = 0; i < 2; i++) begin
            pa[i] = '0;
            pw[i] = '0;
            ps[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst/ready", 32'(pr), 0);
        chk("rst/mem_req", 32'({mem_rd_req, mem_wr_req}), 0);
        chk("rst/mem_addr", 32'(mem_addr), 0);
        chk("rst/wr_data", mem_wr_data, 0);
        resetn = 1'b1;
        @(negedge clk);

        xact("pre_wr", 0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'hDEADBEEF, 0);
        xact("t1_rd", 0, 32'h10, 0, 4'h0, 32'hDEADBEEF, 0, 0);
        xact("t2_wr", 1, 32'h20, 32'h12345678, 4'hF, 0, 32'h12345678, 0);
        xact("t2_rb", 1, 32'h20, 0, 4'h0, 32'h12345678, 0, 0);
        xact("t3_rmw", 1, 32'h20, 32'h0000AB00, 4'b0010, 0, 32'h1234AB78, 0);
        xact("t3_rb", 0, 32'h20, 0, 4'h0, 32'h1234AB78, 0, 0);
        xact("t5_oor", 0, 32'h1000, 0, 4'h0, 0, 0, 1);

        pa[0] = 32'h10;
        pa[1] = 32'h20;
        ps[0] = 4'h0;
        ps[1] = 4'h0;
        resetn = 1'b0;
        pv = 2'b11;
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 40 && seq.size() < 4; c++) begin
            @(negedge clk);
            if (pr[0]) seq.push_back(0);
            if (pr[1]) seq.push_back(1);
        end
        pv = 2'b00;
        chk("t4/grants", 32'(seq.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < seq.size())
                chk($sformatf("t4/grant%0d", i), 32'(seq[i]), 32'(i % 2));
        repeat (2) @(negedge clk);

        pa[0] = 32'h10;
        ps[0] = 4'h0;
        pv[0] = 1'b1;
        @(negedge clk);
        chk("t6/rd_req", 32'(mem_rd_req), 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("t6/mem_req", 32'({mem_rd_req, mem_wr_req}), 0);
        chk("t6/mem_addr", 32'(mem_addr), 0);
        chk("t6/ready", 32'(pr), 0);
        chk("t6/err", 32'(pe), 0);
        chk("t6/rdata0", prd[0], 0);
        pv[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t6/no_ready%0d", c), 32'(pr), 0);
        end
        resetn = 1'b1;
        @(negedge clk);
        xact("t6_rd", 1, 32'h10, 0, 4'h0, 32'hDEADBEEF, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
